axi_lite_arbiter: RTL and testbench

- N-master to 1-slave AXI4-Lite arbiter; the mirror of the 1-to-N address-decoding crossbar.
- Merges several initiators (e.g. IFU and LSU) onto one shared downstream port (memory or the crossbar).
- Read and write paths are arbitrated independently, each with its own round-robin pointer.
- At most one outstanding read and one outstanding write at a time.

---
 rtl/axi_lite_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_axi_lite_arbiter.sv | 480 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_arbiter.sv
// N-to-1 AXI4-Lite arbiter: independent round-robin read and write paths,
// one outstanding transaction per direction, grants registered in the IDLE states.
module axi_lite_arbiter #(
  parameter int unsigned NUM_MASTERS = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  // upstream ports, master i occupies slice i of each vector
  input  logic [NUM_MASTERS-1:0]      m_arvalid,
  output logic [NUM_MASTERS-1:0]      m_arready,
  input  logic [NUM_MASTERS*32-1:0]   m_araddr,
  output logic [NUM_MASTERS-1:0]      m_rvalid,
  input  logic [NUM_MASTERS-1:0]      m_rready,
  output logic [NUM_MASTERS*32-1:0]   m_rdata,
  output logic [NUM_MASTERS*2-1:0]    m_rresp,
  input  logic [NUM_MASTERS-1:0]      m_awvalid,
  output logic [NUM_MASTERS-1:0]      m_awready,
  input  logic [NUM_MASTERS*32-1:0]   m_awaddr,
  input  logic [NUM_MASTERS-1:0]      m_wvalid,
  output logic [NUM_MASTERS-1:0]      m_wready,
  input  logic [NUM_MASTERS*32-1:0]   m_wdata,
  input  logic [NUM_MASTERS*4-1:0]    m_wmask,
  output logic [NUM_MASTERS-1:0]      m_bvalid,
  input  logic [NUM_MASTERS-1:0]      m_bready,
  output logic [NUM_MASTERS*2-1:0]    m_bresp,
  // downstream port
  output logic                        s_arvalid,
  input  logic                        s_arready,
  output logic [31:0]                 s_araddr,
  input  logic                        s_rvalid,
  output logic                        s_rready,
  input  logic [31:0]                 s_rdata,
  input  logic [1:0]                  s_rresp,
  output logic                        s_awvalid,
  input  logic                        s_awready,
  output logic [31:0]                 s_awaddr,
  output logic                        s_wvalid,
  input  logic                        s_wready,
  output logic [31:0]                 s_wdata,
  output logic [3:0]                  s_wmask,
  input  logic                        s_bvalid,
  output logic                        s_bready,
  input  logic [1:0]                  s_bresp
);

  localparam int unsigned OW = $clog2(NUM_MASTERS);

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} wr_state_t;

  rd_state_t       rd_state;
  wr_state_t       wr_state;
  logic [OW-1:0]   rd_owner, rd_ptr, wr_owner, wr_ptr;
  logic            aw_done, w_done;
  logic            aw_hs, w_hs;

  // First requester strictly after ptr, wrapping around.
  function automatic logic [OW-1:0] rr_pick(input logic [NUM_MASTERS-1:0] req,
                                            input logic [OW-1:0] ptr);
    logic [OW-1:0] win;
    logic          found;
    int unsigned   idx;
    win   = ptr;
    found = 1'b0;
    for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
      idx = (32'(ptr) + k) % NUM_MASTERS;
      if (!found && req[idx[OW-1:0]]) begin
        win   = idx[OW-1:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_state <= R_IDLE;
      rd_owner <= '0;
      rd_ptr   <= OW'(NUM_MASTERS - 1);
    end else begin
      case (rd_state)
        R_IDLE: if (|m_arvalid) begin
          rd_owner <= rr_pick(m_arvalid, rd_ptr);
          rd_state <= R_ADDR;
        end
        R_ADDR: if (s_arvalid && s_arready) rd_state <= R_DATA;
        R_DATA: if (s_rvalid && s_rready) begin
          rd_ptr   <= rd_owner;
          rd_state <= R_IDLE;
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_state <= W_IDLE;
      wr_owner <= '0;
      wr_ptr   <= OW'(NUM_MASTERS - 1);
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else begin
      case (wr_state)
        W_IDLE: if (|(m_awvalid | m_wvalid)) begin
          wr_owner <= rr_pick(m_awvalid | m_wvalid, wr_ptr);
          wr_state <= W_ADDR;
        end
        W_ADDR: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
          if ((aw_done || aw_hs) && (w_done || w_hs)) wr_state <= W_RESP;
        end
        W_RESP: if (s_bvalid && s_bready) begin
          aw_done  <= 1'b0;
          w_done   <= 1'b0;
          wr_ptr   <= wr_owner;
          wr_state <= W_IDLE;
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  // Owner muxing is unrolled over masters so every slice index is constant.
  always_comb begin
    m_arready = '0;
    m_rvalid  = '0;
    m_rdata   = '0;
    m_rresp   = '0;
    s_arvalid = 1'b0;
    s_araddr  = '0;
    s_rready  = 1'b0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (OW'(i) == rd_owner) begin
        if (rd_state == R_ADDR) begin
          s_arvalid    = m_arvalid[i];
          s_araddr     = m_araddr[i*32 +: 32];
          m_arready[i] = s_arready;
        end
        if (rd_state == R_DATA) begin
          m_rvalid[i]          = s_rvalid;
          m_rdata[i*32 +: 32]  = s_rdata;
          m_rresp[i*2 +: 2]    = s_rresp;
          s_rready             = m_rready[i];
        end
      end
    end
  end

  always_comb begin
    m_awready = '0;
    m_wready  = '0;
    m_bvalid  = '0;
    m_bresp   = '0;
    s_awvalid = 1'b0;
    s_awaddr  = '0;
    s_wvalid  = 1'b0;
    s_wdata   = '0;
    s_wmask   = '0;
    s_bready  = 1'b0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (OW'(i) == wr_owner) begin
        if (wr_state == W_ADDR) begin
          s_awvalid    = m_awvalid[i] && !aw_done;
          s_awaddr     = m_awaddr[i*32 +: 32];
          m_awready[i] = s_awready && !aw_done;
          s_wvalid     = m_wvalid[i] && !w_done;
          s_wdata      = m_wdata[i*32 +: 32];
          s_wmask      = m_wmask[i*4 +: 4];
          m_wready[i]  = s_wready && !w_done;
        end
        if (wr_state == W_RESP) begin
          m_bvalid[i]       = s_bvalid;
          m_bresp[i*2 +: 2] = s_bresp;
          s_bready          = m_bready[i];
        end
      end
    end
    aw_handshake_calc: begin
      aw_hs = s_awvalid && s_awready;
      w_hs  = s_wvalid && s_wready;
    end
  end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Bench for axi_lite_arbiter with three masters: directed scenarios plus randomized
// read/write rounds checked against a round-robin ordering model.
module tb_axi_lite_arbiter;

  localparam int N = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [N-1:0]    m_arvalid, m_arready, m_rvalid, m_rready;
  logic [N-1:0]    m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [N*32-1:0] m_araddr, m_rdata, m_awaddr, m_wdata;
  logic [N*4-1:0]  m_wmask;
  logic [N*2-1:0]  m_rresp, m_bresp;
  logic            s_arvalid, s_arready, s_rvalid, s_rready;
  logic            s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [31:0]     s_araddr, s_rdata, s_awaddr, s_wdata;
  logic [3:0]      s_wmask;
  logic [1:0]      s_rresp, s_bresp;

  int total_cnt = 0;
  int pass_cnt  = 0;

  axi_lite_arbiter #(.NUM_MASTERS(N)) dut (
    .clk(clk), .reset(reset),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wmask(m_wmask),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wmask(s_wmask),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp)
  );

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [31:0] s32(input logic [N*32-1:0] v, input int i);
    return v[i*32 +: 32];
  endfunction

  function automatic logic [1:0] s2(input logic [N*2-1:0] v, input int i);
    return v[i*2 +: 2];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    m_arvalid = '0; m_araddr = '0; m_rready = '0;
    m_awvalid = '0; m_awaddr = '0; m_wvalid = '0; m_wdata = '0; m_wmask = '0; m_bready = '0;
    s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rresp = '0;
    s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_bresp = '0;
  endtask

  task automatic test_reset();
    logic [4*N+4:0] quiet;
    idle_inputs();
    reset = 1'b0;
    m_arvalid = 3'b001;
    m_araddr[31:0] = 32'h8000_0020;
    s_arready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick(); settle();
      quiet = {s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready,
               m_arready, m_awready, m_wready, m_rvalid, m_bvalid};
      total_cnt++;
      if (quiet !== '0) $display("FAIL reset_quiet: got %b want all zero", quiet);
      else pass_cnt++;
    end
    reset = 1'b1;
    s_arready = 1'b0;
    settle();
    total_cnt++;
    if (s_arvalid !== 1'b0) $display("FAIL reset_idle_latency: s_arvalid %b want 0", s_arvalid);
    else pass_cnt++;
    tick(); settle();
    total_cnt++;
    if (s_arvalid !== 1'b1 || s_araddr !== 32'h8000_0020)
      $display("FAIL reset_first_grant: arvalid %b addr %h want 1 80000020", s_arvalid, s_araddr);
    else pass_cnt++;
    s_arready = 1'b1; settle();
    total_cnt++;
    if (m_arready !== 3'b001) $display("FAIL reset_arready: got %b want 001", m_arready);
    else pass_cnt++;
    tick();
    m_arvalid = '0; s_arready = 1'b0;
    s_rvalid = 1'b1; s_rdata = 32'h0BAD_F00D; m_rready = 3'b001;
    settle();
    total_cnt++;
    if (m_rvalid !== 3'b001 || s32(m_rdata, 0) !== 32'h0BAD_F00D)
      $display("FAIL reset_first_rdata: rvalid %b data %h want 001 0badf00d", m_rvalid, s32(m_rdata, 0));
    else pass_cnt++;
    tick();
    s_rvalid = 1'b0; m_rready = '0;
    // a write abandoned by reset must not leave anything asserted downstream
    m_awvalid = 3'b010; m_awaddr[63:32] = 32'h8000_0040;
    tick(); settle();
    total_cnt++;
    if (s_awvalid !== 1'b1) $display("FAIL reset_abandon_pre: s_awvalid %b want 1", s_awvalid);
    else pass_cnt++;
    reset = 1'b0; tick();
    reset = 1'b1; m_awvalid = '0; settle();
    total_cnt++;
    if ({s_awvalid, s_wvalid, s_bready} !== 3'b000)
      $display("FAIL reset_abandon: aw/w/bready %b want 000", {s_awvalid, s_wvalid, s_bready});
    else pass_cnt++;
  endtask

  task automatic test_single_read();
    idle_inputs();
    m_arvalid = 3'b010;
    m_araddr[63:32] = 32'h8000_0010;
    settle();
    total_cnt++;
    if (s_arvalid !== 1'b0) $display("FAIL single_idle: s_arvalid %b want 0", s_arvalid);
    else pass_cnt++;
    tick(); settle();
    total_cnt++;
    if (s_arvalid !== 1'b1 || s_araddr !== 32'h8000_0010 || m_arready !== 3'b000)
      $display("FAIL single_addr: arvalid %b addr %h arready %b want 1 80000010 000", s_arvalid, s_araddr, m_arready);
    else pass_cnt++;
    s_arready = 1'b1; settle();
    total_cnt++;
    if (m_arready !== 3'b010) $display("FAIL single_arready: got %b want 010", m_arready);
    else pass_cnt++;
    tick();
    m_arvalid = '0; s_arready = 1'b0;
    s_rvalid = 1'b1; s_rdata = 32'hDEAD_BEEF; s_rresp = 2'b00; m_rready = 3'b011;
    settle();
    total_cnt++;
    if (m_rvalid !== 3'b010 || s32(m_rdata, 1) !== 32'hDEAD_BEEF || s2(m_rresp, 1) !== 2'b00)
      $display("FAIL single_rdata: rvalid %b data %h want 010 deadbeef", m_rvalid, s32(m_rdata, 1));
    else pass_cnt++;
    total_cnt++;
    if (s32(m_rdata, 0) !== 32'h0 || s_rready !== 1'b1)
      $display("FAIL single_nonowner: m0 data %h rready %b want 0 1", s32(m_rdata, 0), s_rready);
    else pass_cnt++;
    tick();
    s_rvalid = 1'b0; m_rready = '0; settle();
    total_cnt++;
    if (m_rvalid !== 3'b000) $display("FAIL single_done: rvalid %b want 000", m_rvalid);
    else pass_cnt++;
  endtask

  task automatic test_contention();
    int          exp;
    bit          done;
    logic [N-1:0] own;
    logic [31:0] a, tag;
    idle_inputs();
    reset = 1'b0;
    m_arvalid = 3'b011;
    m_araddr[31:0] = 32'h8000_0000;
    m_araddr[63:32] = 32'h8000_0004;
    m_rready = 3'b011;
    tick();
    reset = 1'b1;
    for (int t = 0; t < 4; t++) begin
      exp = t % 2;
      done = 1'b0; own = '0; a = '0;
      s_arready = 1'b1;
      for (int c = 0; c < 10 && !done; c++) begin
        settle();
        if (s_arvalid && s_arready) begin done = 1'b1; own = m_arready; a = s_araddr; end
        tick();
      end
      total_cnt++;
      if (!done || own !== oh(exp))
        $display("FAIL contention_grant%0d: arready %b done %0d want %b", t, own, done, oh(exp));
      else pass_cnt++;
      s_arready = 1'b0;
      s_rvalid = 1'b1;
      s_rdata = (a == 32'h8000_0000) ? 32'hA0 : 32'hB1;
      settle();
      tag = (exp == 0) ? 32'hA0 : 32'hB1;
      total_cnt++;
      if (m_rvalid !== oh(exp) || s32(m_rdata, exp) !== tag || s32(m_rdata, 1 - exp) !== 32'h0)
        $display("FAIL contention_route%0d: rvalid %b data %h want %b %h", t, m_rvalid, s32(m_rdata, exp), oh(exp), tag);
      else pass_cnt++;
      tick();
      s_rvalid = 1'b0;
    end
    m_arvalid = '0;
    // drain the grant already taken for the next request
    s_arready = 1'b1;
    for (int c = 0; c < 3; c++) tick();
    s_arready = 1'b0; s_rvalid = 1'b1; m_rready = '1;
    tick();
    idle_inputs();
  endtask

  task automatic test_split_write();
    int  aw_n, w_n, wready_cycles;
    bit  in_resp, aw_taken;
    logic [31:0] got_aw;
    idle_inputs();
    m_wvalid = 3'b001; m_wdata[31:0] = 32'h1234_5678; m_wmask[3:0] = 4'hF;
    m_awaddr[31:0] = 32'h8000_0100; m_bready = 3'b001;
    s_wready = 1'b1;
    aw_n = 0; w_n = 0; wready_cycles = 0; in_resp = 1'b0; aw_taken = 1'b0; got_aw = '0;
    for (int c = 0; c < 15 && !in_resp; c++) begin
      m_awvalid[0] = (c >= 2) && !aw_taken;
      s_awready = (c >= 5);
      settle();
      if (s_bready) in_resp = 1'b1;
      else begin
        if (m_wready[0]) wready_cycles++;
        if (s_wvalid && s_wready) begin
          w_n++;
          total_cnt++;
          if (s_wdata !== 32'h1234_5678 || s_wmask !== 4'hF)
            $display("FAIL split_wdata: %h/%h want 12345678/f", s_wdata, s_wmask);
          else pass_cnt++;
        end
        if (s_awvalid && s_awready) begin aw_n++; got_aw = s_awaddr; aw_taken = 1'b1; end
        tick();
      end
    end
    total_cnt++;
    if (!in_resp || aw_n != 1 || w_n != 1)
      $display("FAIL split_handshakes: resp %0d aw %0d w %0d want 1 1 1", in_resp, aw_n, w_n);
    else pass_cnt++;
    total_cnt++;
    if (wready_cycles != 1 || got_aw !== 32'h8000_0100)
      $display("FAIL split_wready_once: wready cycles %0d awaddr %h want 1 80000100", wready_cycles, got_aw);
    else pass_cnt++;
    m_wvalid = '0; m_awvalid = '0; s_awready = 1'b0; s_wready = 1'b0;
    s_bvalid = 1'b1; s_bresp = 2'b01; settle();
    total_cnt++;
    if (m_bvalid !== 3'b001 || s2(m_bresp, 0) !== 2'b01)
      $display("FAIL split_bresp: bvalid %b bresp %b want 001 01", m_bvalid, s2(m_bresp, 0));
    else pass_cnt++;
    tick();
    idle_inputs();
  endtask

  task automatic test_concurrent();
    idle_inputs();
    m_arvalid = 3'b001; m_araddr[31:0] = 32'h8000_0200;
    m_awvalid = 3'b010; m_wvalid = 3'b010;
    m_awaddr[63:32] = 32'h8000_0300; m_wdata[63:32] = 32'hCAFE_F00D; m_wmask[7:4] = 4'h3;
    tick(); settle();
    total_cnt++;
    if (s_arvalid !== 1'b1 || s_araddr !== 32'h8000_0200 || s_awvalid !== 1'b1 || s_wvalid !== 1'b1)
      $display("FAIL concurrent_fwd: ar %b %h aw %b w %b want 1 80000200 1 1", s_arvalid, s_araddr, s_awvalid, s_wvalid);
    else pass_cnt++;
    total_cnt++;
    if (s_awaddr !== 32'h8000_0300 || s_wdata !== 32'hCAFE_F00D || s_wmask !== 4'h3)
      $display("FAIL concurrent_wpath: %h %h %h want 80000300 cafef00d 3", s_awaddr, s_wdata, s_wmask);
    else pass_cnt++;
    s_arready = 1'b1; s_awready = 1'b1; s_wready = 1'b1; settle();
    total_cnt++;
    if (m_arready !== 3'b001 || m_awready !== 3'b010 || m_wready !== 3'b010)
      $display("FAIL concurrent_ready: ar %b aw %b w %b want 001 010 010", m_arready, m_awready, m_wready);
    else pass_cnt++;
    tick();
    idle_inputs();
    s_rvalid = 1'b1; s_rdata = 32'h1111_2222; s_bvalid = 1'b1; s_bresp = 2'b10;
    m_rready = 3'b001; m_bready = 3'b010; settle();
    total_cnt++;
    if (m_rvalid !== 3'b001 || s32(m_rdata, 0) !== 32'h1111_2222 || m_bvalid !== 3'b010 || s2(m_bresp, 1) !== 2'b10)
      $display("FAIL concurrent_resp: rvalid %b rdata %h bvalid %b bresp %b", m_rvalid, s32(m_rdata, 0), m_bvalid, s2(m_bresp, 1));
    else pass_cnt++;
    total_cnt++;
    if (s_rready !== 1'b1 || s_bready !== 1'b1)
      $display("FAIL concurrent_rdy: rready %b bready %b want 1 1", s_rready, s_bready);
    else pass_cnt++;
    tick();
    idle_inputs(); settle();
    total_cnt++;
    if ({s_rready, s_bready, s_arvalid, s_awvalid} !== 4'b0000)
      $display("FAIL concurrent_idle: %b want 0000", {s_rready, s_bready, s_arvalid, s_awvalid});
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    idle_inputs();
    m_arvalid = 3'b100; m_araddr[95:64] = 32'h8000_0400;
    tick();
    s_arready = 1'b1; tick();
    m_arvalid = 3'b001; m_araddr[31:0] = 32'h8000_0500; s_arready = 1'b0;
    s_rvalid = 1'b1; s_rdata = 32'h7777_0000;
    for (int c = 0; c < 4; c++) begin
      settle();
      total_cnt++;
      if (s_rready !== 1'b0 || m_rvalid !== 3'b100 || s_arvalid !== 1'b0)
        $display("FAIL backpressure_hold%0d: rready %b rvalid %b arvalid %b want 0 100 0", c, s_rready, m_rvalid, s_arvalid);
      else pass_cnt++;
      tick();
    end
    m_rready = 3'b100; settle();
    total_cnt++;
    if (s_rready !== 1'b1) $display("FAIL backpressure_release: rready %b want 1", s_rready);
    else pass_cnt++;
    tick();
    s_rvalid = 1'b0; m_rready = '0; settle();
    total_cnt++;
    if (s_arvalid !== 1'b0) $display("FAIL backpressure_gap: arvalid %b want 0", s_arvalid);
    else pass_cnt++;
    tick(); settle();
    total_cnt++;
    if (s_arvalid !== 1'b1 || s_araddr !== 32'h8000_0500)
      $display("FAIL backpressure_next: arvalid %b addr %h want 1 80000500", s_arvalid, s_araddr);
    else pass_cnt++;
    s_arready = 1'b1; tick();
    m_arvalid = '0; s_arready = 1'b0; s_rvalid = 1'b1; m_rready = 3'b001;
    tick();
    idle_inputs();
  endtask

  // Reference: with a fixed request set and no new arrivals, service order is the
  // requesters sorted by distance after the last-served master.
  task automatic test_random_reads();
    int           last, exp;
    int           order[$];
    logic [31:0]  addr[N];
    logic [N-1:0] req, own;
    logic [31:0]  got_addr;
    logic [1:0]   rr;
    bit           done;
    idle_inputs();
    reset = 1'b0; tick(); reset = 1'b1;
    last = N - 1;
    for (int r = 0; r < 12; r++) begin
      req = N'($urandom_range(1, (1 << N) - 1));
      order.delete();
      for (int k = 1; k <= N; k++) if (req[(last + k) % N]) order.push_back((last + k) % N);
      for (int i = 0; i < N; i++) begin
        addr[i] = 32'h8000_0000 | ($urandom & 32'h0000_FFFC);
        m_araddr[i*32 +: 32] = addr[i];
      end
      m_arvalid = req;
      while (order.size() > 0) begin
        exp = order.pop_front();
        done = 1'b0; own = '0; got_addr = '0;
        for (int c = 0; c < 40 && !done; c++) begin
          s_arready = 1'($urandom_range(0, 1));
          settle();
          if (s_arvalid && s_arready) begin done = 1'b1; own = m_arready; got_addr = s_araddr; end
          tick();
        end
        total_cnt++;
        if (!done || own !== oh(exp) || got_addr !== addr[exp])
          $display("FAIL rand_rd_grant r%0d: done %0d arready %b addr %h want %b %h", r, done, own, got_addr, oh(exp), addr[exp]);
        else pass_cnt++;
        m_arvalid[exp] = 1'b0; s_arready = 1'b0;
        for (int d = $urandom_range(0, 2); d > 0; d--) tick();
        rr = 2'($urandom);
        s_rvalid = 1'b1; s_rdata = addr[exp] ^ 32'h5A5A_A5A5; s_rresp = rr;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
          m_rready = $urandom_range(0, 1) ? oh(exp) : '0;
          settle();
          if (s_rvalid && s_rready) begin
            done = 1'b1;
            total_cnt++;
            if (m_rvalid !== oh(exp) || s32(m_rdata, exp) !== (addr[exp] ^ 32'h5A5A_A5A5) || s2(m_rresp, exp) !== rr)
              $display("FAIL rand_rd_data r%0d: rvalid %b data %h resp %b want %b %h %b", r, m_rvalid,
                       s32(m_rdata, exp), s2(m_rresp, exp), oh(exp), addr[exp] ^ 32'h5A5A_A5A5, rr);
            else pass_cnt++;
          end
          tick();
        end
        total_cnt++;
        if (!done) $display("FAIL rand_rd_timeout r%0d: no response handshake for master %0d", r, exp);
        else pass_cnt++;
        s_rvalid = 1'b0; m_rready = '0;
        last = exp;
      end
    end
    idle_inputs();
  endtask

  task automatic test_random_writes();
    int           last, exp, aw_n, w_n;
    int           order[$];
    logic [31:0]  addr[N], data[N];
    logic [3:0]   mask[N];
    logic [N-1:0] req, aw_m, w_m, aw_own, w_own;
    logic [35:0]  got_w;
    logic [31:0]  got_aw;
    logic [1:0]   br;
    bit           in_resp;
    idle_inputs();
    reset = 1'b0; tick(); reset = 1'b1;
    last = N - 1;
    for (int r = 0; r < 12; r++) begin
      req = N'($urandom_range(1, (1 << N) - 1));
      order.delete();
      for (int k = 1; k <= N; k++) if (req[(last + k) % N]) order.push_back((last + k) % N);
      for (int i = 0; i < N; i++) begin
        addr[i] = 32'h8000_0000 | ($urandom & 32'h0000_FFFC);
        data[i] = $urandom;
        mask[i] = 4'($urandom_range(1, 15));
        m_awaddr[i*32 +: 32] = addr[i];
        m_wdata[i*32 +: 32]  = data[i];
        m_wmask[i*4 +: 4]    = mask[i];
      end
      m_awvalid = req; m_wvalid = req;
      while (order.size() > 0) begin
        exp = order.pop_front();
        aw_n = 0; w_n = 0; in_resp = 1'b0;
        aw_own = '0; w_own = '0; got_aw = '0; got_w = '0;
        m_bready = oh(exp);
        for (int c = 0; c < 60 && !in_resp; c++) begin
          s_awready = 1'($urandom_range(0, 1));
          s_wready  = 1'($urandom_range(0, 1));
          settle();
          if (s_bready) in_resp = 1'b1;
          else begin
            aw_m = '0; w_m = '0;
            if (s_awvalid && s_awready) begin aw_n++; got_aw = s_awaddr; aw_own = m_awready; aw_m = m_awready; end
            if (s_wvalid && s_wready) begin w_n++; got_w = {s_wmask, s_wdata}; w_own = m_wready; w_m = m_wready; end
            tick();
            m_awvalid = m_awvalid & ~aw_m;
            m_wvalid  = m_wvalid & ~w_m;
          end
        end
        total_cnt++;
        if (!in_resp || aw_n != 1 || w_n != 1)
          $display("FAIL rand_wr_hs r%0d: resp %0d aw %0d w %0d want 1 1 1", r, in_resp, aw_n, w_n);
        else pass_cnt++;
        total_cnt++;
        if (aw_own !== oh(exp) || w_own !== oh(exp) || got_aw !== addr[exp] || got_w !== {mask[exp], data[exp]})
          $display("FAIL rand_wr_owner r%0d: aw %b w %b addr %h data %h want %b %h %h", r, aw_own, w_own,
                   got_aw, got_w, oh(exp), addr[exp], {mask[exp], data[exp]});
        else pass_cnt++;
        s_awready = 1'b0; s_wready = 1'b0;
        br = 2'($urandom);
        s_bvalid = 1'b1; s_bresp = br; settle();
        total_cnt++;
        if (m_bvalid !== oh(exp) || s2(m_bresp, exp) !== br)
          $display("FAIL rand_wr_b r%0d: bvalid %b bresp %b want %b %b", r, m_bvalid, s2(m_bresp, exp), oh(exp), br);
        else pass_cnt++;
        tick();
        s_bvalid = 1'b0; m_bready = '0;
        last = exp;
      end
    end
    idle_inputs();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    idle_inputs();
    tick();
    test_reset();
    test_single_read();
    test_contention();
    test_split_write();
    test_concurrent();
    test_backpressure();
    test_random_reads();
    test_random_writes();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
